// File: rtl/rvga_icache_pkg.sv
// Shared types for the rvga instruction cache.
//   - rvga_icache_state  : controller state encoding (IDLE, REQ, FILL)
//   - RVGA_ICACHE_SETS   : default number of lines
//   - RVGA_ICACHE_WORDS  : default 32-bit words per line
//   - rvga_icache_addr_t : tag/index/offset view of a fetch word address
//   - rvga_icache_split  : splits a word address (byte address [31:2])
package rvga_types;

  localparam int RVGA_ICACHE_SETS   = 64;
  localparam int RVGA_ICACHE_WORDS  = 4;
  localparam int RVGA_ICACHE_WOFF_W = $clog2(RVGA_ICACHE_WORDS);
  localparam int RVGA_ICACHE_IDX_W  = $clog2(RVGA_ICACHE_SETS);
  localparam int RVGA_ICACHE_TAG_W  = 32 - RVGA_ICACHE_IDX_W - RVGA_ICACHE_WOFF_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } rvga_icache_state;

  typedef struct packed {
    logic [RVGA_ICACHE_TAG_W-1:0]  tag;
    logic [RVGA_ICACHE_IDX_W-1:0]  idx;
    logic [RVGA_ICACHE_WOFF_W-1:0] woff;
  } rvga_icache_addr_t;

  // The struct fields are ordered MSB-first, so a plain cast of the word
  // address lands every field in place.
  function automatic rvga_icache_addr_t rvga_icache_split(input logic [29:0] word_addr);
    return rvga_icache_addr_t'(word_addr);
  endfunction

endpackage

// File: rtl/rvga_icache_array.sv
// Flop-based storage for the instruction cache.
//   clk_i, rst_i        : clock, asynchronous active-low reset (clears valid only)
//   rd_idx_i/rd_woff_i  : asynchronous read address
//   rd_valid_o/rd_tag_o/rd_data_o : read results for rd_idx_i (data at rd_woff_i)
//   wr_en_i, wr_idx_i, wr_woff_i, wr_data_i : one-word data write port
//   tag_we_i, tag_i, valid_set_i : tag write for wr_idx_i, optionally setting valid
//   flash_clr_i         : clears every valid bit at the clock edge
module rvga_icache_array
  import rvga_types::*;
#(
  parameter int SETS  = RVGA_ICACHE_SETS,
  parameter int WORDS = RVGA_ICACHE_WORDS,
  parameter int TAG_W = RVGA_ICACHE_TAG_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(SETS)-1:0]  rd_idx_i,
  input  logic [$clog2(WORDS)-1:0] rd_woff_i,
  output logic                     rd_valid_o,
  output logic [TAG_W-1:0]         rd_tag_o,
  output logic [31:0]              rd_data_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(SETS)-1:0]  wr_idx_i,
  input  logic [$clog2(WORDS)-1:0] wr_woff_i,
  input  logic [31:0]              wr_data_i,
  input  logic                     tag_we_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic                     valid_set_i,
  input  logic                     flash_clr_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][WORDS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_woff_i];

  // Flash clear wins over a same-cycle valid set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else if (flash_clr_i) begin
      valid_q <= '0;
    end else if (tag_we_i && valid_set_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_woff_i] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_q[wr_idx_i] <= tag_i;
    end
  end

endmodule

// File: rtl/rvga_icache.sv
// Direct-mapped read-only instruction cache.
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   imem_addr_i    : fetch byte address (bits [1:0] ignored)
//   imem_data_o    : instruction word, zero unless imem_resp_v_o
//   imem_resp_v_o  : same-cycle hit for imem_addr_i (only in IDLE)
//   inv_v_i        : one-cycle pulse, invalidate every line
//   mem_r_v_o      : line-fill request, held until mem_gnt_i
//   mem_addr_o     : line-aligned fill address
//   mem_gnt_i      : memory accepted the request
//   mem_data_i, mem_resp_v_i : fill beats, word 0 first, gaps allowed
//
// Handshake: a request is transferred on the cycle where mem_r_v_o and
// mem_gnt_i are both high; mem_r_v_o and mem_addr_o stay stable until then.
// Every cycle in FILL with mem_resp_v_i high delivers exactly one beat.
module rvga_icache
  import rvga_types::*;
#(
  parameter int SETS           = RVGA_ICACHE_SETS,
  parameter int WORDS_PER_LINE = RVGA_ICACHE_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_resp_v_o,
  input  logic        inv_v_i,
  output logic        mem_r_v_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_resp_v_i
);

  localparam int WOFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - WOFF - 2;
  localparam int LINE_W = 32 - WOFF - 2;
  localparam logic [WOFF-1:0] LAST_BEAT = WOFF'(WORDS_PER_LINE - 1);

  rvga_icache_state  state_q;
  logic [WOFF-1:0]   cnt_q;
  logic              inv_pend_q;
  logic              mem_r_v_q;
  logic [LINE_W-1:0] miss_line_q;

  logic [WOFF-1:0]   a_woff;
  logic [IDX_W-1:0]  a_idx;
  logic [TAG_W-1:0]  a_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;
  logic              beat;
  logic              last_beat;
  logic              unused_addr_bits;

  assign a_woff = imem_addr_i[2 +: WOFF];
  assign a_idx  = imem_addr_i[2 + WOFF +: IDX_W];
  assign a_tag  = imem_addr_i[31 -: TAG_W];
  assign unused_addr_bits = ^imem_addr_i[1:0];

  // An invalidate in the same cycle masks the hit, since the line is gone
  // after this edge.
  assign hit = (state_q == IDLE) && rd_valid && (rd_tag == a_tag) && !inv_v_i;

  assign beat      = (state_q == FILL) && mem_resp_v_i;
  assign last_beat = beat && (cnt_q == LAST_BEAT);

  assign imem_resp_v_o = hit;
  assign imem_data_o   = hit ? rd_data : 32'h0;
  assign mem_r_v_o     = mem_r_v_q;
  assign mem_addr_o    = {miss_line_q, {(WOFF + 2){1'b0}}};

  rvga_icache_array #(
    .SETS  (SETS),
    .WORDS (WORDS_PER_LINE),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (a_idx),
    .rd_woff_i   (a_woff),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (beat),
    .wr_idx_i    (miss_line_q[IDX_W-1:0]),
    .wr_woff_i   (cnt_q),
    .wr_data_i   (mem_data_i),
    .tag_we_i    (last_beat),
    .tag_i       (miss_line_q[LINE_W-1 -: TAG_W]),
    // A line whose fill overlapped an invalidate is stored but stays invalid.
    .valid_set_i (!inv_pend_q && !inv_v_i),
    .flash_clr_i (inv_v_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inv_pend_q  <= 1'b0;
      mem_r_v_q   <= 1'b0;
      miss_line_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!inv_v_i && !hit) begin
            miss_line_q <= imem_addr_i[31:WOFF+2];
            mem_r_v_q   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (inv_v_i) begin
            inv_pend_q <= 1'b1;
          end
          if (mem_gnt_i) begin
            mem_r_v_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (inv_v_i) begin
            inv_pend_q <= 1'b1;
          end
          if (beat) begin
            cnt_q <= cnt_q + WOFF'(1);
          end
          if (last_beat) begin
            inv_pend_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  a_gnt_in_req : assert property (@(posedge clk_i) disable iff (!rst_i)
    mem_gnt_i |-> (state_q == REQ));
  a_beat_in_fill : assert property (@(posedge clk_i) disable iff (!rst_i)
    mem_resp_v_i |-> (state_q == FILL));

endmodule

// File: tb/tb_rvga_icache.sv
module tb_rvga_icache;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] imem_addr_i = 32'h0;
  logic [31:0] imem_data_o;
  logic        imem_resp_v_o;
  logic        inv_v_i = 1'b0;
  logic        mem_r_v_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_data_i = 32'h0;
  logic        mem_resp_v_i = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  rvga_icache dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_addr_i   (imem_addr_i),
    .imem_data_o   (imem_data_o),
    .imem_resp_v_o (imem_resp_v_o),
    .inv_v_i       (inv_v_i),
    .mem_r_v_o     (mem_r_v_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_data_i    (mem_data_i),
    .mem_resp_v_i  (mem_resp_v_i)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic wait_req(input string nm, input logic [31:0] exp_addr);
    int budget = 0;
    while (mem_r_v_o !== 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    check({nm, "_req"}, 32'(mem_r_v_o), 32'h1);
    check({nm, "_addr"}, mem_addr_o, exp_addr);
  endtask

  task automatic fill_line(input string nm, input logic [31:0] exp_addr, input logic [31:0] base,
                           input int gnt_delay, input bit gapped, input bit redirect,
                           input logic [31:0] redir_addr, input bit inv_mid);
    wait_req(nm, exp_addr);
    if (mem_r_v_o !== 1'b1) return;
    for (int d = 0; d < gnt_delay; d++) begin
      step();
      check({nm, "_hold"}, {mem_r_v_o, mem_addr_o[30:0]}, {1'b1, exp_addr[30:0]});
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    settle();
    check({nm, "_req_drop"}, 32'(mem_r_v_o), 32'h0);
    for (int w = 0; w < 4; w++) begin
      if (gapped) begin
        for (int g = 0; g <= (w % 3); g++) step();
      end
      if (inv_mid && w == 2) begin
        inv_v_i = 1'b1;
        step();
        inv_v_i = 1'b0;
      end
      if (redirect && w == 2) imem_addr_i = redir_addr;
      settle();
      check({nm, "_fill_resp"}, 32'(imem_resp_v_o), 32'h0);
      mem_resp_v_i = 1'b1;
      mem_data_i   = base + 32'(w);
      step();
      mem_resp_v_i = 1'b0;
      mem_data_i   = 32'h0;
    end
    settle();
  endtask

  task automatic expect_hit(input string nm, input logic [31:0] addr, input logic [31:0] exp_data);
    imem_addr_i = addr;
    settle();
    check({nm, "_hit"}, 32'(imem_resp_v_o), 32'h1);
    check({nm, "_data"}, imem_data_o, exp_data);
  endtask

  task automatic expect_miss(input string nm, input logic [31:0] addr);
    imem_addr_i = addr;
    settle();
    check({nm, "_miss"}, 32'(imem_resp_v_o), 32'h0);
  endtask

  // Directed sequence
  initial begin
    // Reset state
    settle();
    check("rst_resp_v", 32'(imem_resp_v_o), 32'h0);
    check("rst_data", imem_data_o, 32'h0);
    check("rst_mem_r_v", 32'(mem_r_v_o), 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    step();
    step();
    rst_i = 1'b1;

    // Cold miss: grant after 2 cycles, back-to-back beats
    expect_miss("cold", 32'h0000_0104);
    fill_line("cold", 32'h0000_0100, 32'hA0, 2, 1'b0, 1'b0, 32'h0, 1'b0);
    check("cold_refetch_hit", 32'(imem_resp_v_o), 32'h1);
    check("cold_refetch_data", imem_data_o, 32'hA1);

    // Hit path
    expect_hit("hit0", 32'h0000_0100, 32'hA0);
    step();
    expect_hit("hit2", 32'h0000_0108, 32'hA2);
    check("hit2_no_req", 32'(mem_r_v_o), 32'h0);
    step();
    expect_hit("hit3", 32'h0000_010C, 32'hA3);
    step();
    check("hit3_no_req", 32'(mem_r_v_o), 32'h0);

    // Conflict eviction: 0x500 shares index 16 with 0x100
    expect_miss("conf", 32'h0000_0500);
    fill_line("conf", 32'h0000_0500, 32'hB0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("conf_data", imem_data_o, 32'hB0);
    expect_miss("conf_evicted", 32'h0000_0100);

    // Gapped beats with a redirect to 0x200 mid-fill
    fill_line("gap", 32'h0000_0100, 32'hC0, 1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    check("redir_miss", 32'(imem_resp_v_o), 32'h0);
    fill_line("redir", 32'h0000_0200, 32'hD0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_hit("redir", 32'h0000_0208, 32'hD2);
    expect_hit("gap_line", 32'h0000_0104, 32'hC1);

    // Invalidate in IDLE
    inv_v_i = 1'b1;
    settle();
    check("inv_idle_mask", 32'(imem_resp_v_o), 32'h0);
    step();
    inv_v_i = 1'b0;
    expect_miss("inv_idle", 32'h0000_0100);
    fill_line("inv_idle", 32'h0000_0100, 32'hE0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("inv_idle_refill", imem_data_o, 32'hE0);

    // Invalidate during FILL: line lands but stays invalid, 0x100 dropped too
    expect_miss("inv_fill", 32'h0000_0300);
    fill_line("inv_fill", 32'h0000_0300, 32'h30, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("inv_fill_not_valid", 32'(imem_resp_v_o), 32'h0);
    fill_line("inv_refill", 32'h0000_0300, 32'h40, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("inv_refill_data", imem_data_o, 32'h40);
    expect_miss("inv_fill_other", 32'h0000_0100);
    fill_line("other", 32'h0000_0100, 32'h50, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("other_data", imem_data_o, 32'h50);

    // Reset after 2 of 4 beats
    expect_miss("rmid", 32'h0000_0400);
    wait_req("rmid", 32'h0000_0400);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'h60 + 32'(w);
      step();
    end
    mem_resp_v_i = 1'b0;
    rst_i = 1'b0;
    settle();
    check("rmid_resp_v", 32'(imem_resp_v_o), 32'h0);
    check("rmid_data", imem_data_o, 32'h0);
    check("rmid_mem_r_v", 32'(mem_r_v_o), 32'h0);
    check("rmid_mem_addr", mem_addr_o, 32'h0);
    step();
    rst_i = 1'b1;
    expect_miss("rmid_after", 32'h0000_0400);
    wait_req("rmid_after", 32'h0000_0400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rvga_icache.md
Name: rvga_icache

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction-fetch port and a line-fill memory port.
- Core side: returns a hit in the same cycle as the address. On a miss it holds `imem_resp_v_o` low, which stalls fetch through the hazard unit, then fills the whole line from memory.
- Memory side: a request/grant handshake followed by a sequence of word beats.
- Supports a whole-cache invalidate for fence.i.

Parameters:
- SETS, 64, number of lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- imem_addr_i  in  32  fetch byte address; bits [1:0] ignored
- imem_data_o  out  32  instruction word; valid only when imem_resp_v_o=1
- imem_resp_v_o  out  1  hit for the current imem_addr_i
- inv_v_i  in  1  single-cycle pulse; invalidate all lines
- mem_r_v_o  out  1  line-fill request
- mem_addr_o  out  32  line-aligned fill address
- mem_gnt_i  in  1  memory accepts the request
- mem_data_i  in  32  fill beat data
- mem_resp_v_i  in  1  fill beat valid

Behaviour:
- Address split:
  - word offset = addr[2 +: WOFF], where WOFF = log2(WORDS_PER_LINE)
  - index = next log2(SETS) bits
  - tag = remaining upper bits (TAG_W)
- Storage: valid[SETS], tag[SETS][TAG_W], data[SETS][WORDS_PER_LINE][32]. All flop-based with asynchronous read.
- Reset (rst_i=0, asynchronous):
  - state = IDLE; all valid bits cleared; beat counter = 0; inv_pend = 0.
  - Outputs: imem_resp_v_o=0, imem_data_o=0, mem_r_v_o=0, mem_addr_o=0.
  - Tag/data contents are don't-care.
- IDLE:
  - hit = valid[idx] & (tag[idx] == addr tag) & ~inv_v_i.
  - On hit: imem_resp_v_o=1 and imem_data_o = data[idx][woff], both combinational in the same cycle (0-cycle hit latency).
  - On miss and no inv_v_i: latch the miss line address into miss_addr, go to REQ.
  - inv_v_i in IDLE: clear all valid bits at the clock edge; stay IDLE; imem_resp_v_o=0 that cycle.
- REQ:
  - mem_r_v_o=1 and mem_addr_o = {miss_addr line bits, (WOFF+2)'b0}, held stable until mem_gnt_i.
  - On mem_gnt_i: go to FILL with counter=0. mem_r_v_o drops in the following cycle.
- FILL:
  - mem_r_v_o=0.
  - Each cycle with mem_resp_v_i: data[miss_idx][counter] <= mem_data_i; counter increments, wrapping to 0.
  - Beats arrive in ascending word order starting at word 0; gaps between beats are allowed.
  - On the beat with counter == WORDS_PER_LINE-1: write tag[miss_idx] and set valid[miss_idx] (unless inv_pend or inv_v_i), clear inv_pend, return to IDLE.
  - The refetch hits on the first IDLE cycle, i.e. one cycle after the last beat.
- imem_resp_v_o=0 throughout REQ and FILL, regardless of address.
- Address change during a miss (flush redirect): the fill completes into the latched miss_addr line. On return to IDLE the current imem_addr_i is looked up fresh and may miss again.
- inv_v_i during REQ/FILL:
  - Clear all valid bits immediately and set inv_pend.
  - The in-flight line is written but its valid bit is not set.
- mem_resp_v_i outside FILL and mem_gnt_i outside REQ are ignored (protocol error; flagged by assertion).
- A conflicting fill overwrites the line at the same index (no victim writeback; read-only cache).
- Reset mid-fill returns to IDLE with all lines invalid. Memory is required to discard the outstanding transaction on reset.

Decomposition:
- In package rvga_types:
  - rvga_icache_state enum {IDLE, REQ, FILL}
  - RVGA_ICACHE_SETS and RVGA_ICACHE_WORDS constants
  - an address-split helper struct (tag/index/offset) derived from them
- One sub-module, rvga_icache_array:
  - valid/tag/data storage
  - asynchronous read port
  - one word-write port plus tag/valid write port
  - flash valid-clear input
- The top of rvga_icache holds only the FSM, counter, inv_pend and muxing.

Test Plan:
- Cold miss:
  - Stimulus: reset, addr=0x0000_0104; grant after 2 cycles; beats 0xA0..0xA3 on consecutive cycles.
  - Required: mem_addr_o=0x0000_0100; imem_resp_v_o=0 until one cycle after the last beat, then 1 with data=0xA1.
- Hit path:
  - Stimulus: after the cold-miss fill, step addr through 0x100, 0x108, 0x10C.
  - Required: imem_resp_v_o=1 every cycle with data 0xA0, 0xA2, 0xA3; mem_r_v_o stays 0.
- Conflict eviction (SETS=64, 16-byte lines):
  - Stimulus: fetch 0x100, then 0x500 (same index, different tag).
  - Required: miss and refill with mem_addr_o=0x500; then 0x100 misses again.
- Gapped beats plus redirect:
  - Stimulus: beats separated by 1–3 idle cycles; imem_addr_i changes to 0x200 mid-fill.
  - Required: the 0x100 line is completed and valid; 0x200 then issues a new request.
- Invalidate:
  - Stimulus: inv_v_i pulse in IDLE after filling 0x100; separately, inv_v_i during FILL.
  - Required: both cases cause a subsequent miss on 0x100. In the FILL case, the in-flight line is not marked valid.
- Reset mid-FILL:
  - Stimulus: assert rst_i=0 after 2 of 4 beats.
  - Required: all outputs 0 immediately; after release, a fetch of the same line misses and issues a new mem_r_v_o.
